// File: rtl/route_buffer_ms_pkg.sv
// Shared location codes, load FSM encoding and default sizes for the multi-slot route buffer.
package route_buffer_ms_pkg;

    typedef enum logic [1:0] {
        RTE_IFM  = 2'b00,
        RTE_BUF  = 2'b01,
        RTE_DRAM = 2'b10
    } rte_loc_e;

    typedef enum logic [1:0] {
        LD_IDLE  = 2'b00,
        LD_RUN   = 2'b01,
        LD_DRAIN = 2'b10,
        LD_DONE  = 2'b11
    } ld_state_e;

    localparam int ROUTE_BUFFER_DEPTH = 4096;
    localparam int ROUTE_BUFFER_AW    = 12;
    localparam int FM_BUFFER_DW       = 32;
    localparam int FM_BUFFER_AW       = 16;
    localparam int W_FRAME_SIZE_DEF   = 16;
    localparam int DEF_NUM_SLOTS      = 2;

    // Slot index width: clog2 of the slot count, never narrower than one bit.
    function automatic int slot_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dpram_wrapper.sv
// Simple dual-port RAM, one write and one registered read port; contents are not reset.
module dpram_wrapper #(
    parameter int DW    = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 4096
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array write and synchronous read.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem_q[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/route_slot_bank.sv
// Bank of independent route slots: one RAM per slot, decoded write enable, registered read-slot mux.
module route_slot_bank
    import route_buffer_ms_pkg::*;
#(
    parameter int NUM_SLOTS  = DEF_NUM_SLOTS,
    parameter int SLOT_W     = slot_idx_w(DEF_NUM_SLOTS),
    parameter int SLOT_DEPTH = ROUTE_BUFFER_DEPTH,
    parameter int SLOT_AW    = ROUTE_BUFFER_AW,
    parameter int FM_DW      = FM_BUFFER_DW
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               wr_en,
    input  logic [SLOT_W-1:0]  wr_slot,
    input  logic [SLOT_AW-1:0] wr_addr,
    input  logic [FM_DW-1:0]   wr_data,
    input  logic               rd_en,
    input  logic [SLOT_W-1:0]  rd_slot,
    input  logic [SLOT_AW-1:0] rd_addr,
    output logic [FM_DW-1:0]   rd_data
);

    logic [FM_DW-1:0]  rdata_s [NUM_SLOTS];
    logic [SLOT_W-1:0] rd_slot_d;
    logic [SLOT_W-1:0] rd_slot_q;

    for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
        dpram_wrapper #(
            .DW    (FM_DW),
            .AW    (SLOT_AW),
            .DEPTH (SLOT_DEPTH)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en & (wr_slot == SLOT_W'(i))),
            .waddr (wr_addr),
            .wdata (wr_data),
            .re    (rd_en & (rd_slot == SLOT_W'(i))),
            .raddr (rd_addr),
            .rdata (rdata_s[i])
        );
    end

    // Read-slot select follows the RAM read latency so the mux lines up with the data.
    always_comb begin
        if (rd_en) begin
            rd_slot_d = rd_slot;
        end else begin
            rd_slot_d = rd_slot_q;
        end
    end

    // Read-slot select register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_slot_q <= '0;
        end else begin
            rd_slot_q <= rd_slot_d;
        end
    end

    // One-hot AND-OR output mux over the slot RAMs.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            rd_data = rd_data | ({FM_DW{rd_slot_q == SLOT_W'(i)}} & rdata_s[i]);
        end
    end

endmodule

// File: rtl/route_buffer_ms.sv
// Multi-slot route buffer: saves postprocessor maps into slots and reloads them onto the IFM aux port.
// Optional feature macro: ROUTE_OOB_CHK_EN (drop out-of-range saves, flag rte_err, clamp load frame size).
module route_buffer_ms
    import route_buffer_ms_pkg::*;
#(
    parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
    parameter int SLOT_W       = slot_idx_w(NUM_SLOTS),
    parameter int SLOT_DEPTH   = ROUTE_BUFFER_DEPTH,
    parameter int SLOT_AW      = ROUTE_BUFFER_AW,
    parameter int FM_DW        = FM_BUFFER_DW,
    parameter int IFM_AW       = FM_BUFFER_AW,
    parameter int W_FRAME_SIZE = W_FRAME_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [W_FRAME_SIZE-1:0] q_frame_size,
    input  logic                    q_route_save,
    input  logic                    q_route_load,
    input  logic [1:0]              q_route_loc,
    input  logic [SLOT_W-1:0]       q_save_slot,
    input  logic [SLOT_W-1:0]       q_load_slot,
    input  logic [IFM_AW-1:0]       q_route_offset,
    input  logic                    pp_data_vld,
    input  logic [FM_DW-1:0]        pp_data,
    input  logic [IFM_AW-1:0]       pp_addr,
    input  logic                    rte_buf_load_req,
    output logic                    rte_buf_load_done,
    output logic                    rte_aux_vld,
    output logic                    rte_aux_write_vld,
    output logic [IFM_AW-1:0]       rte_aux_write_addr,
    output logic [FM_DW-1:0]        rte_aux_write_data,
    output logic                    rte_err
);

    localparam int CNT_W = SLOT_AW + 1;
    localparam int CMP_W = (W_FRAME_SIZE > CNT_W) ? W_FRAME_SIZE : CNT_W;

    logic                    ifm_save_s;
    logic                    buf_save_s;
    logic                    load_mode_s;
    logic                    oob_s;
    logic                    wr_en_s;
    logic                    issue_s;
    logic                    last_s;
    logic [W_FRAME_SIZE-1:0] frame_eff_s;
    logic [FM_DW-1:0]        rd_data_s;

    ld_state_e               state_d, state_q;
    logic [CNT_W-1:0]        cnt_d, cnt_q;
    logic [SLOT_W-1:0]       slot_d, slot_q;
    logic                    ld_vld_d, ld_vld_q;
    logic [IFM_AW-1:0]       ld_addr_d, ld_addr_q;
    logic                    done_d, done_q;
    logic                    err_d, err_q;

    assign ifm_save_s  = q_route_save & (q_route_loc == RTE_IFM);
    assign buf_save_s  = q_route_save & (q_route_loc == RTE_BUF);
    assign load_mode_s = q_route_load & (q_route_loc == RTE_BUF);

    // Range filter for BUF saves and load frame clamp; both are inert without the check.
    always_comb begin
`ifdef ROUTE_OOB_CHK_EN
        oob_s = (32'(pp_addr) >= 32'(SLOT_DEPTH));
        if (32'(q_frame_size) > 32'(SLOT_DEPTH)) begin
            frame_eff_s = W_FRAME_SIZE'(SLOT_DEPTH);
        end else begin
            frame_eff_s = q_frame_size;
        end
`else
        oob_s       = 1'b0;
        frame_eff_s = q_frame_size;
`endif
        wr_en_s = buf_save_s & pp_data_vld & ~oob_s;
        err_d   = err_q | (buf_save_s & pp_data_vld & oob_s);
    end

    assign last_s = (CMP_W'(cnt_q) == (CMP_W'(frame_eff_s) - CMP_W'(1)));

    // Load FSM next state; a falling load request aborts from any state and kills the in-flight beat.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        slot_d    = slot_q;
        ld_addr_d = ld_addr_q;
        ld_vld_d  = 1'b0;
        issue_s   = 1'b0;
        if (!q_route_load) begin
            state_d = LD_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                LD_IDLE: begin
                    if (load_mode_s) begin
                        slot_d = q_load_slot;
                        cnt_d  = '0;
                        if (frame_eff_s == '0) begin
                            state_d = LD_DONE;
                        end else begin
                            state_d = LD_RUN;
                        end
                    end else begin
                        state_d = LD_IDLE;
                    end
                end
                LD_RUN: begin
                    // Only issue while this block owns the aux port as a loader.
                    if (load_mode_s && rte_buf_load_req && !ifm_save_s) begin
                        issue_s   = 1'b1;
                        ld_vld_d  = 1'b1;
                        ld_addr_d = q_route_offset + IFM_AW'(cnt_q);
                        cnt_d     = cnt_q + CNT_W'(1);
                        if (last_s) begin
                            state_d = LD_DRAIN;
                        end else begin
                            state_d = LD_RUN;
                        end
                    end else begin
                        state_d = LD_RUN;
                    end
                end
                LD_DRAIN: state_d = LD_DONE;
                LD_DONE:  state_d = LD_DONE;
                default:  state_d = LD_IDLE;
            endcase
        end
        done_d = (state_d == LD_DONE);
    end

    // Load FSM, counter, registered beat and status flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= LD_IDLE;
            cnt_q     <= '0;
            slot_q    <= '0;
            ld_vld_q  <= 1'b0;
            ld_addr_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
            ld_vld_q  <= ld_vld_d;
            ld_addr_q <= ld_addr_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    route_slot_bank #(
        .NUM_SLOTS  (NUM_SLOTS),
        .SLOT_W     (SLOT_W),
        .SLOT_DEPTH (SLOT_DEPTH),
        .SLOT_AW    (SLOT_AW),
        .FM_DW      (FM_DW)
    ) u_bank (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (wr_en_s),
        .wr_slot (q_save_slot),
        .wr_addr (pp_addr[SLOT_AW-1:0]),
        .wr_data (pp_data),
        .rd_en   (issue_s),
        .rd_slot (slot_q),
        .rd_addr (cnt_q[SLOT_AW-1:0]),
        .rd_data (rd_data_s)
    );

    // Aux port mux: the zero-latency IFM save has priority over a reload beat.
    always_comb begin
        if (ifm_save_s) begin
            rte_aux_write_vld  = pp_data_vld;
            rte_aux_write_addr = q_route_offset + pp_addr;
            rte_aux_write_data = pp_data;
        end else if (load_mode_s && ld_vld_q) begin
            rte_aux_write_vld  = 1'b1;
            rte_aux_write_addr = ld_addr_q;
            rte_aux_write_data = rd_data_s;
        end else begin
            rte_aux_write_vld  = 1'b0;
            rte_aux_write_addr = '0;
            rte_aux_write_data = '0;
        end
    end

    assign rte_aux_vld       = ifm_save_s | load_mode_s;
    assign rte_buf_load_done = done_q;
    assign rte_err           = err_q;

endmodule

// File: tb/tb_route_buffer_ms.sv
// Randomised scoreboard bench for route_buffer_ms against a slot-memory reference model.
module tb_route_buffer_ms;
    import route_buffer_ms_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] q_frame_size;
    logic        q_route_save, q_route_load;
    logic [1:0]  q_route_loc;
    logic        q_save_slot, q_load_slot;
    logic [15:0] q_route_offset;
    logic        pp_data_vld;
    logic [31:0] pp_data;
    logic [15:0] pp_addr;
    logic        rte_buf_load_req;
    logic        rte_buf_load_done, rte_aux_vld, rte_aux_write_vld, rte_err;
    logic [15:0] rte_aux_write_addr;
    logic [31:0] rte_aux_write_data;

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] ref_mem [int];
    bit          ref_err = 1'b0;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;

    route_buffer_ms dut (
        .clk                (clk),
        .rstn               (rstn),
        .q_frame_size       (q_frame_size),
        .q_route_save       (q_route_save),
        .q_route_load       (q_route_load),
        .q_route_loc        (q_route_loc),
        .q_save_slot        (q_save_slot),
        .q_load_slot        (q_load_slot),
        .q_route_offset     (q_route_offset),
        .pp_data_vld        (pp_data_vld),
        .pp_data            (pp_data),
        .pp_addr            (pp_addr),
        .rte_buf_load_req   (rte_buf_load_req),
        .rte_buf_load_done  (rte_buf_load_done),
        .rte_aux_vld        (rte_aux_vld),
        .rte_aux_write_vld  (rte_aux_write_vld),
        .rte_aux_write_addr (rte_aux_write_addr),
        .rte_aux_write_data (rte_aux_write_data),
        .rte_err            (rte_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every aux write beat must match the oldest expectation, including its cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && rte_aux_write_vld) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: got addr=%h data=%h cyc=%0d, required no beat",
                             rte_aux_write_addr, rte_aux_write_data, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (rte_aux_write_addr !== mon_e.addr || rte_aux_write_data !== mon_e.data ||
                        cyc != mon_e.cyc || rte_aux_vld !== 1'b1) begin
                        fails++;
                        $display("FAIL aux_beat: got addr=%h data=%h cyc=%0d aux_vld=%b, required addr=%h data=%h cyc=%0d aux_vld=1",
                                 rte_aux_write_addr, rte_aux_write_data, cyc, rte_aux_vld,
                                 mon_e.addr, mon_e.data, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int a, input logic [31:0] d, input int c);
        exp_t e;
        e.addr = a[15:0];
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic idle_inputs();
        q_frame_size = 16'd0; q_route_save = 1'b0; q_route_load = 1'b0;
        q_route_loc = RTE_IFM; q_save_slot = 1'b0; q_load_slot = 1'b0;
        q_route_offset = 16'd0; pp_data_vld = 1'b0; pp_data = 32'd0;
        pp_addr = 16'd0; rte_buf_load_req = 1'b0;
    endtask

    task automatic save_buf(input int slot, input int addr, input logic [31:0] data);
        q_route_loc = RTE_BUF; q_route_save = 1'b1; q_save_slot = 1'(slot);
        pp_data_vld = 1'b1; pp_addr = 16'(addr); pp_data = data;
        tick();
        pp_data_vld = 1'b0; q_route_save = 1'b0;
`ifdef ROUTE_OOB_CHK_EN
        if (addr >= 4096) ref_err = 1'b1;
        else ref_mem[slot * 4096 + addr] = data;
`else
        ref_mem[slot * 4096 + (addr % 4096)] = data;
`endif
    endtask

    task automatic ifm_save(input int n, input int offset);
        q_route_offset = 16'(offset); q_route_loc = RTE_IFM; q_route_save = 1'b1;
        for (int k = 0; k < n; k++) begin
            pp_data_vld = 1'b1; pp_addr = 16'(k); pp_data = $urandom;
            push_exp(offset + k, pp_data, cyc);
            tick();
        end
        pp_data_vld = 1'b0; q_route_save = 1'b0;
        tick();
    endtask

    // mode: 0 req always, 1 req pattern 1,0,1,..., 2 random req.
    // stop_kind at stop_at beats: 0 clean abort, 1 abort killing the in-flight beat, 2 reset.
    task automatic do_load(input int slot, input int frame, input int offset, input int mode,
                           input int stop_at, input int stop_kind, input int arb_at);
        int issued = 0;
        int guard  = 0;
        bit arb_done = 1'b0;
        bit r;
        q_load_slot = 1'(slot); q_frame_size = 16'(frame); q_route_offset = 16'(offset);
        q_route_loc = RTE_BUF; q_route_load = 1'b1; rte_buf_load_req = 1'b0;
        check("done_low_at_start", 64'(rte_buf_load_done), 64'd0);
        tick();
        if (frame == 0) begin
            check("done_frame0", 64'(rte_buf_load_done), 64'd1);
        end else begin
            while (issued < frame && guard < 400) begin
                if (issued == stop_at) break;
                if (issued == arb_at && !arb_done) begin
                    rte_buf_load_req = 1'b0;
                    tick();
                    q_route_loc = RTE_IFM; q_route_save = 1'b1; rte_buf_load_req = 1'b1;
                    for (int k = 0; k < 3; k++) begin
                        pp_data_vld = 1'b1; pp_addr = 16'($urandom_range(0, 255)); pp_data = $urandom;
                        push_exp(offset + int'(pp_addr), pp_data, cyc);
                        tick();
                    end
                    pp_data_vld = 1'b0; q_route_save = 1'b0; q_route_loc = RTE_BUF;
                    arb_done = 1'b1;
                end
                case (mode)
                    0:       r = 1'b1;
                    1:       r = ((guard % 3) != 1);
                    default: r = 1'($urandom_range(0, 1));
                endcase
                rte_buf_load_req = r;
                if (r) begin
                    push_exp(offset + issued, ref_mem[slot * 4096 + issued], cyc + 1);
                    issued++;
                end
                tick();
                guard++;
            end
            if (stop_at >= 0 && issued == stop_at) begin
                if (stop_kind == 1) begin
                    q_route_load = 1'b0; rte_buf_load_req = 1'b0;
                    void'(exp_q.pop_back());
                    tick();
                end else begin
                    rte_buf_load_req = 1'b0;
                    tick();
                    if (stop_kind == 2) begin
                        rstn = 1'b0;
                        #1;
                        check("rst_mid_write_vld", 64'(rte_aux_write_vld), 64'd0);
                        check("rst_mid_done", 64'(rte_buf_load_done), 64'd0);
                        ref_err = 1'b0;
                        q_route_load = 1'b0;
                        tick();
                        rstn = 1'b1;
                    end else begin
                        q_route_load = 1'b0; rte_buf_load_req = 1'b1;
                    end
                end
                repeat (4) tick();
                check("abort_no_done", 64'(rte_buf_load_done), 64'd0);
                rte_buf_load_req = 1'b0;
            end else begin
                rte_buf_load_req = 1'b0;
                check("done_in_drain", 64'(rte_buf_load_done), 64'd0);
                tick();
                check("done_after_last", 64'(rte_buf_load_done), 64'd1);
            end
        end
        q_route_load = 1'b0;
        tick();
        check("done_cleared", 64'(rte_buf_load_done), 64'd0);
    endtask

    initial begin
        idle_inputs();
        repeat (3) tick();
        check("rst_write_vld", 64'(rte_aux_write_vld), 64'd0);
        check("rst_aux_vld", 64'(rte_aux_vld), 64'd0);
        check("rst_addr", 64'(rte_aux_write_addr), 64'd0);
        check("rst_data", 64'(rte_aux_write_data), 64'd0);
        check("rst_done", 64'(rte_buf_load_done), 64'd0);
        check("rst_err", 64'(rte_err), 64'd0);
        rstn = 1'b1;
        tick();

        ifm_save(4, 'h100);

        for (int k = 0; k < 8; k++) save_buf(0, k, 32'hA0 + 32'(k));
        for (int k = 0; k < 8; k++) save_buf(1, k, 32'hB0 + 32'(k));
        do_load(1, 8, 'h40, 0, -1, 0, -1);
        do_load(0, 8, $urandom_range(0, 65535), 2, -1, 0, -1);
        do_load(1, 5, 'h80, 1, -1, 0, -1);
        do_load(0, 0, 'h10, 0, -1, 0, -1);
        do_load(0, 4, 'hFFFE, 0, -1, 0, -1);

        for (int k = 0; k < 10; k++) save_buf(0, k, $urandom);
        do_load(0, 10, 'h200, 0, 3, 0, -1);
        do_load(0, 10, 'h200, 0, -1, 0, -1);
        do_load(0, 6, 'h600, 1, 2, 1, -1);
        do_load(1, 8, 'h700, 0, -1, 0, 3);
        do_load(1, 8, 'h500, 0, 2, 2, -1);
        do_load(1, 8, 'h500, 0, -1, 0, -1);

        save_buf(0, 0, 32'h1111_0000);
        save_buf(0, 4096, 32'h2222_0000);
        check("oob_err", 64'(rte_err), 64'(ref_err));
        do_load(0, 1, 'h300, 0, -1, 0, -1);
        repeat (3) tick();
        check("oob_err_hold", 64'(rte_err), 64'(ref_err));

        for (int it = 0; it < 6; it++) begin
            int slot = $urandom_range(0, 1);
            int n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) save_buf(slot, k, $urandom);
            do_load(slot, n, $urandom_range(0, 65535), 2, -1, 0, -1);
        end

        repeat (4) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/route_buffer_ms.md
# route_buffer_ms

Multi-slot route buffer between the postprocessor and the IFM buffer manager's aux write port. It holds up to NUM_SLOTS independent feature maps for YOLO route/concat layers. Each slot is saved from postprocessor output and later reloaded into the IFM buffer at a programmable offset, so multiple live route sources are possible. It is the successor of the single-slot route buffer: it adds slot selection, a load FSM with explicit drain and abort, aux-port arbitration and optional address checking.

## Interface
- NUM_SLOTS, 2, number of route slots (1..4)
- SLOT_W, 1, slot index width, equals clog2(NUM_SLOTS) with a minimum of 1
- SLOT_DEPTH, `ROUTE_BUFFER_DEPTH (4096), words per slot
- SLOT_AW, `ROUTE_BUFFER_AW (12), slot address width
- FM_DW, `FM_BUFFER_DW (32), data width
- IFM_AW, `FM_BUFFER_AW, IFM/OFM address width
- W_FRAME_SIZE, `W_FRAME_SIZE, frame word-count width
- clk  in  1  clock; single clock domain
- rstn  in  1  asynchronous, active-low reset
- q_frame_size  in  W_FRAME_SIZE  number of words to load
- q_route_save  in  1  layer-level save mode, held for the whole layer
- q_route_load  in  1  layer-level load mode, held until done
- q_route_loc  in  2  location: 00 = IFM, 01 = BUF, 10 = DRAM (unsupported, behaves as idle)
- q_save_slot  in  SLOT_W  destination slot for a BUF save
- q_load_slot  in  SLOT_W  source slot for a BUF load
- q_route_offset  in  IFM_AW  IFM base address
- pp_data_vld  in  1  postprocessor beat valid
- pp_data  in  FM_DW  postprocessor data
- pp_addr  in  IFM_AW  postprocessor OFM address
- rte_buf_load_req  in  1  level; load beats are issued only while high
- rte_buf_load_done  out  1  load complete, sticky
- rte_aux_vld  out  1  this block owns the aux port
- rte_aux_write_vld  out  1  aux write strobe
- rte_aux_write_addr  out  IFM_AW  aux write address
- rte_aux_write_data  out  FM_DW  aux write data
- rte_err  out  1  sticky out-of-range save flag

## Operation
- IFM save (save=1, loc=00): combinational pass-through to the aux port; write_vld=pp_data_vld, addr=q_route_offset+pp_addr, data=pp_data.
- BUF save (save=1, loc=01): each pp_data_vld beat writes slot q_save_slot at pp_addr[SLOT_AW-1:0]. Other slots are untouched.
- BUF load FSM, states IDLE, RUN, DRAIN, DONE:
  - IDLE: when load=1 and loc=01, go to RUN with cnt=0 and slot latched. If q_frame_size=0, go directly to DONE.
  - RUN: on every cycle with req=1 and no stall, read the latched slot at cnt and increment cnt. After the beat with cnt=q_frame_size-1 is issued, go to DRAIN.
  - DRAIN: wait one cycle for the last read data, then go to DONE.
  - DONE: rte_buf_load_done=1. Return to IDLE when q_route_load falls.
- Abort: if q_route_load falls in any state, go to IDLE the next cycle, clear cnt, and drop any in-flight beat (no write_vld).
- Stall: if save=1 with loc=00 while load is active, the IFM save owns the aux port and RUN issues nothing that cycle.
- rte_aux_vld = (save & loc=00) | (load & loc=01).
- All output muxes drive zero when not selected.
- Address arithmetic: offset+cnt and offset+pp_addr are computed modulo 2^IFM_AW (wrap, no saturation). cnt is SLOT_AW+1 bits wide, and q_frame_size is compared at full width.
- Save and load on different slots in the same layer are legal. Save and load on the same slot at the same time are undefined.

## Timing
- Reset values: every output is 0, FSM is IDLE, cnt is 0, rte_err is 0. Slot RAM contents are not reset.
- Load latency: a read issued in cycle t produces rte_aux_write_vld in cycle t+1, with addr = offset + cnt(t) registered alongside.
- Throughput is one word per cycle while req=1.
- Done rises in the cycle after the last write beat and for q_frame_size=0 one cycle after load start.
- IFM save is zero-latency (combinational).
- A reset asserted mid-load clears state immediately (asynchronous). The next load restarts from cnt=0.

## Configuration
- ROUTE_OOB_CHK_EN defined: a BUF save with pp_addr >= SLOT_DEPTH is dropped, and rte_err is set sticky until reset. A load with q_frame_size > SLOT_DEPTH is clamped to SLOT_DEPTH.
- ROUTE_OOB_CHK_EN not defined: addresses are truncated to SLOT_AW bits (aliasing), no clamping, rte_err is tied to 0.

## Structure
- controller_params.vh holds:
  - RTE_IFM/RTE_BUF/RTE_DRAM location codes
  - load FSM state encodings
  - ROUTE_BUFFER_DEPTH/AW
  - the default NUM_SLOTS
- Sub-module route_slot_bank contains:
  - a generate loop of NUM_SLOTS dpram_wrapper instances (write enable decoded from the save slot)
  - a registered read-slot select driving the output mux.

## Test plan
- IFM save: offset=0x100, pp beats at addr 0..3 -> aux writes to 0x100..0x103 in the same cycle, data unchanged, rte_aux_vld=1.
- Two-slot save/load:
  - stimulus: save 0xA0..0xA7 to slot 0 and 0xB0..0xB7 to slot 1, then load slot 1 with frame=8, offset=0x40
  - required: 8 beats 0xB0..0xB7 at 0x40..0x47, one cycle after each issue; done one cycle after the last beat.
- Backpressure: toggle req 1,0,1,1,0,1... over frame=5 -> exactly 5 beats, ordered, no duplicates or skips.
- Frame 0 and abort:
  - frame=0: done one cycle after load start, no write_vld.
  - abort: drop q_route_load after 3 of 10 beats -> FSM in IDLE, no further beats; a reload from 0 succeeds.
- Arbitration: assert IFM save during RUN -> aux carries save beats only, load cnt frozen, load resumes afterwards.
- ROUTE_OOB_CHK_EN: save at pp_addr=4096 -> write suppressed, rte_err=1 held; without the macro it aliases to word 0 and rte_err=0.
